// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main control unit.
//   - state_t   : controller state encoding (also visible on state_o)
//   - OP_*      : primary opcodes (IR[31:26]) the controller decodes
//   - ALUOP_*   : ALU operation select encodings
//   - SRCB_*    : ALU B-operand mux encodings
//   - PCSRC_*   : PC source mux encodings
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_mc_control.sv
// Multicycle MIPS main control unit.
// Sequences each instruction through fetch/decode/execute/memory/write-back
// states and drives the datapath strobes.
//
// Ports:
//   clk, rst        : clock (rising edge), synchronous active-low reset
//   opcode          : IR[31:26], valid from DECODE onward
//   mem_ready       : memory finishes the current access this cycle
//   zero            : ALU zero flag (consumed by the datapath in BRANCH)
//   PCWrite .. PCSource : datapath enables and mux selects
//   state_o         : current state encoding
//   illegal         : high during the DECODE cycle of an unknown opcode
//   retired         : saturating count of completed instructions
//
// Handshake: a memory access in FETCH, MEMRD or MEMWR holds its request
// (MemRead/MemWrite) every cycle until the cycle in which mem_ready is 1;
// that cycle completes the access and the FSM moves on at the next edge.
// mem_ready in any other state has no effect.
module mips_mc_control
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    input  logic             zero,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [3:0]       state_o,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_t state;
    state_t state_next;
    state_t out_state;
    logic   retire;
    logic   known_op;

    // The branch decision itself is made in the datapath (PCWriteCond & zero);
    // the controller only needs zero to be an acknowledged input.
    logic   zero_unused;
    assign zero_unused = zero;

    assign state_o = state;

    always_comb begin
        known_op = 1'b0;
        case (opcode)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI: known_op = 1'b1;
            default:                                       known_op = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; retire flags the last cycle of a completed instruction
    always_comb begin
        state_next = S_FETCH;
        retire     = 1'b0;
        case (state)
            S_FETCH:  state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXEC;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_J:         state_next = S_JUMP;
                    OP_ADDI:      state_next = S_ADDIEX;
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEMADR: state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  begin state_next = S_FETCH; retire = 1'b1; end
            S_MEMWR:  begin
                state_next = mem_ready ? S_FETCH : S_MEMWR;
                retire     = mem_ready;
            end
            S_EXEC:   state_next = S_RWB;
            S_RWB:    begin state_next = S_FETCH; retire = 1'b1; end
            S_BRANCH: begin state_next = S_FETCH; retire = 1'b1; end
            S_JUMP:   begin state_next = S_FETCH; retire = 1'b1; end
            S_ADDIEX: state_next = S_ADDIWB;
            S_ADDIWB: begin state_next = S_FETCH; retire = 1'b1; end
            default:  state_next = S_FETCH;
        endcase
    end

    // While reset is held the strobes look like a quiet FETCH, whatever the
    // register currently holds, so nothing downstream sees a stray write.
    assign out_state = rst ? state : S_FETCH;

    // Output decode (Moore, except the fetch-time IR/PC loads)
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_RT;
        ALUOp       = ALUOP_ADD;
        PCSource    = PCSRC_ALU;
        illegal     = 1'b0;
        case (out_state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = mem_ready & rst;
                PCWrite = mem_ready & rst;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMM_SH;
                illegal = ~known_op;
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
            end
            default: ;
        endcase
    end

    // Retired-instruction counter, saturating at all-ones
    always_ff @(posedge clk) begin
        if (!rst) begin
            retired <= '0;
        end else if (retire && !(&retired)) begin
            retired <= retired + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mips_mc_control.sv
module tb_mips_mc_control;

    logic        clk;
    logic        rst;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        zero;

    logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [3:0]  state;
    logic [31:0] retired;

    // Narrow-counter instance sharing the same stimulus (saturation check)
    logic        n_pc_write, n_pc_write_cond, n_iord, n_mem_read, n_mem_write, n_ir_write;
    logic        n_mem_to_reg, n_reg_dst, n_reg_write, n_alu_src_a, n_illegal;
    logic [1:0]  n_alu_src_b, n_alu_op, n_pc_source;
    logic [3:0]  n_state;
    logic [3:0]  n_retired;

    // Expected entry: {retired4, retired32, illegal, state, strobes}
    logic [56:0] exp_q[$];
    logic [31:0] cnt;
    int          total;
    int          bad;

    mips_mc_control #(.CNT_W(32)) u_dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
        .PCWrite(pc_write), .PCWriteCond(pc_write_cond), .IorD(iord),
        .MemRead(mem_read), .MemWrite(mem_write), .IRWrite(ir_write),
        .MemtoReg(mem_to_reg), .RegDst(reg_dst), .RegWrite(reg_write),
        .ALUSrcA(alu_src_a), .ALUSrcB(alu_src_b), .ALUOp(alu_op),
        .PCSource(pc_source), .state_o(state), .illegal(illegal), .retired(retired)
    );

    mips_mc_control #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
        .PCWrite(n_pc_write), .PCWriteCond(n_pc_write_cond), .IorD(n_iord),
        .MemRead(n_mem_read), .MemWrite(n_mem_write), .IRWrite(n_ir_write),
        .MemtoReg(n_mem_to_reg), .RegDst(n_reg_dst), .RegWrite(n_reg_write),
        .ALUSrcA(n_alu_src_a), .ALUSrcB(n_alu_src_b), .ALUOp(n_alu_op),
        .PCSource(n_pc_source), .state_o(n_state), .illegal(n_illegal), .retired(n_retired)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, queue=%0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    // ---------------- reference tables ----------------
    localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5;
    localparam int EXEC = 6, RWB = 7, BRANCH = 8, JUMP = 9, ADDIEX = 10, ADDIWB = 11;

    // Strobe vector per state, packed as
    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource}
    function automatic logic [15:0] strobes_for(int s, logic mr);
        logic pw, pwc, io, mrd, mwr, irw, m2r, rd, rw, sa;
        logic [1:0] sb, op, ps;
        {pw, pwc, io, mrd, mwr, irw, m2r, rd, rw, sa} = '0;
        sb = 2'b00; op = 2'b00; ps = 2'b00;
        case (s)
            FETCH:  begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
            DECODE: sb = 2'b11;
            MEMADR: begin sa = 1; sb = 2'b10; end
            MEMRD:  begin mrd = 1; io = 1; end
            MEMWB:  begin rw = 1; m2r = 1; end
            MEMWR:  begin mwr = 1; io = 1; end
            EXEC:   begin sa = 1; op = 2'b10; end
            RWB:    begin rw = 1; rd = 1; end
            BRANCH: begin sa = 1; op = 2'b01; pwc = 1; ps = 2'b01; end
            JUMP:   begin pw = 1; ps = 2'b10; end
            ADDIEX: begin sa = 1; sb = 2'b10; end
            ADDIWB: rw = 1;
            default: ;
        endcase
        return {pw, pwc, io, mrd, mwr, irw, m2r, rd, rw, sa, sb, op, ps};
    endfunction

    function automatic bit is_known(logic [5:0] op);
        return op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
               op == 6'b000100 || op == 6'b000010 || op == 6'b001000;
    endfunction

    // ---------------- driver tasks ----------------
    // One clock cycle: drive mem_ready, record what the DUT should show this cycle.
    task automatic cyc(input int st, input logic mr, input logic ill);
        logic [3:0] r4;
        logic [3:0] st4;
        r4  = (cnt > 32'd15) ? 4'd15 : cnt[3:0];
        st4 = st[3:0];
        mem_ready = mr;
        exp_q.push_back({r4, cnt, ill, st4, strobes_for(st, mr)});
        @(posedge clk);
        #1;
    endtask

    task automatic reset_cycles(input int n);
        rst = 1'b0;
        mem_ready = 1'($urandom_range(0, 1));
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        cnt = 0;
    endtask

    task automatic do_fetch(input int fw);
        for (int i = 0; i < fw; i++) begin
            opcode = 6'($urandom);
            cyc(FETCH, 1'b0, 1'b0);
        end
        opcode = 6'($urandom);
        cyc(FETCH, 1'b1, 1'b0);
    endtask

    // Full instruction: fw not-ready FETCH cycles, mw not-ready memory cycles.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input logic z);
        logic rnd;
        zero = z;
        do_fetch(fw);
        opcode = op;
        rnd = 1'($urandom_range(0, 1));
        cyc(DECODE, rnd, !is_known(op));
        case (op)
            6'b100011: begin
                cyc(MEMADR, 1'($urandom_range(0, 1)), 1'b0);
                for (int i = 0; i < mw; i++) cyc(MEMRD, 1'b0, 1'b0);
                cyc(MEMRD, 1'b1, 1'b0);
                cyc(MEMWB, 1'($urandom_range(0, 1)), 1'b0);
            end
            6'b101011: begin
                cyc(MEMADR, 1'($urandom_range(0, 1)), 1'b0);
                for (int i = 0; i < mw; i++) cyc(MEMWR, 1'b0, 1'b0);
                cyc(MEMWR, 1'b1, 1'b0);
            end
            6'b000000: begin
                cyc(EXEC, 1'($urandom_range(0, 1)), 1'b0);
                cyc(RWB, 1'($urandom_range(0, 1)), 1'b0);
            end
            6'b000100: cyc(BRANCH, 1'($urandom_range(0, 1)), 1'b0);
            6'b000010: cyc(JUMP, 1'($urandom_range(0, 1)), 1'b0);
            6'b001000: begin
                cyc(ADDIEX, 1'($urandom_range(0, 1)), 1'b0);
                cyc(ADDIWB, 1'($urandom_range(0, 1)), 1'b0);
            end
            default: ;
        endcase
        if (is_known(op) && cnt != 32'hFFFF_FFFF) cnt = cnt + 1;
    endtask

    // ---------------- scoreboard / monitor ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [56:0] e;
        logic [15:0] act_strobes;
        if (rst === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act_strobes = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};
            chk("state",    {28'd0, state},       {28'd0, e[19:16]});
            chk("strobes",  {16'd0, act_strobes}, {16'd0, e[15:0]});
            chk("illegal",  {31'd0, illegal},     {31'd0, e[20]});
            chk("retired",  retired,              e[52:21]);
            chk("state4",   {28'd0, n_state},     {28'd0, e[19:16]});
            chk("retired4", {28'd0, n_retired},   {28'd0, e[56:53]});
        end
    end

    // ---------------- stimulus ----------------
    logic [5:0] rop;

    initial begin
        total = 0;
        bad   = 0;
        cnt   = 0;
        opcode = 6'd0;
        zero   = 1'b0;
        reset_cycles(3);

        // Directed: R-type, stalled lw, beq taken / not taken, illegal opcode
        run_instr(6'b000000, 0, 0, 1'b0);
        run_instr(6'b100011, 2, 3, 1'b0);
        run_instr(6'b000100, 0, 0, 1'b1);
        run_instr(6'b000100, 0, 0, 1'b0);
        run_instr(6'b111111, 0, 0, 1'b0);
        run_instr(6'b101011, 1, 2, 1'b0);
        run_instr(6'b001000, 0, 0, 1'b0);

        // Reset while stalled in MEMRD: partial lw is abandoned
        zero = 1'b0;
        do_fetch(0);
        opcode = 6'b100011;
        cyc(DECODE, 1'b1, 1'b0);
        cyc(MEMADR, 1'b1, 1'b0);
        cyc(MEMRD, 1'b0, 1'b0);
        cyc(MEMRD, 1'b0, 1'b0);
        reset_cycles(3);
        run_instr(6'b000000, 0, 0, 1'b0);

        // Saturation of the narrow counter
        for (int i = 0; i < 16; i++) run_instr(6'b000010, 0, 0, 1'b0);

        // Randomized instruction mix with random memory stalls
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 13))
                0, 1:   rop = 6'b100011;
                2, 3:   rop = 6'b101011;
                4, 5:   rop = 6'b000000;
                6, 7:   rop = 6'b000100;
                8, 9:   rop = 6'b000010;
                10, 11: rop = 6'b001000;
                default: begin
                    rop = 6'($urandom);
                    while (is_known(rop)) rop = 6'($urandom);
                end
            endcase
            run_instr(rop, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        // Last pushed cycle is consumed at the following negedge
        @(negedge clk);
        #1;
        chk("queue_drain", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
- Multicycle MIPS main control unit.
- Sequences each instruction through fetch, decode, execute, memory and write-back states.
- Drives the register-file write enable (RegWrite) and the write-register select (RegDst) that feed the 32x32 register file directly downstream, plus all datapath mux and enable strobes.
- Includes a memory ready handshake and a retired-instruction counter for bring-up.

Parameters:
- CNT_W, 32, width of the retired-instruction counter (saturating).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-low; sampled on rising clk
- opcode  in  6  IR[31:26], valid from DECODE onward
- mem_ready  in  1  memory completes the current read/write this cycle
- zero  in  1  ALU zero flag, used in BRANCH
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if zero
- IorD  out  1  memory address select: 0=PC, 1=ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  write-back data: 0=ALUOut, 1=MDR
- RegDst  out  1  write register: 0=rt, 1=rd
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  0=PC, 1=rs
- ALUSrcB  out  2  00=rt, 01=4, 10=sign-extended imm, 11=imm<<2
- ALUOp  out  2  00=add, 01=sub, 10=funct
- PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target
- state_o  out  4  current state encoding
- illegal  out  1  one-cycle pulse on unknown opcode
- retired  out  CNT_W  count of completed instructions

Behaviour:
- Reset: rst=0 at a clk edge forces state FETCH, retired=0, illegal=0. This applies mid-instruction too; partial work is abandoned and no write strobe follows.
- While rst=0, all strobes are 0 except the FETCH Moore outputs; the bench checks strobes from the first cycle after rst returns to 1.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11.
- Outputs are Moore. The only exceptions are IRWrite and PCWrite in FETCH, which are gated by mem_ready.
- Any strobe not listed for a state is 0. Output defaults: ALUOp=00, ALUSrcB=00, PCSource=00.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite=PCWrite=mem_ready.
  - Stay in FETCH until mem_ready=1, then go to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Dispatch on opcode:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 (R-type) -> EXEC
  - 000100 (beq) -> BRANCH
  - 000010 (j) -> JUMP
  - 001000 (addi) -> ADDIEX
  - anything else -> FETCH with illegal=1 for that cycle; retired is not incremented.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Hold until mem_ready, then go to MEMWB.
- MEMWB: RegWrite=1, RegDst=0, MemtoReg=1. Go to FETCH.
- MEMWR: MemWrite=1, IorD=1. Hold until mem_ready, then go to FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Go to RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0. Go to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Go to FETCH.
- JUMP: PCWrite=1, PCSource=10. Go to FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0. Go to FETCH.
- Retired counter:
  - Increments by 1 on every transition into FETCH from MEMWB, MEMWR (on mem_ready), RWB, BRANCH, JUMP or ADDIWB.
  - Saturates at all-ones.
- Unused encodings 12-15 return to FETCH on the next edge with all strobes 0.
- RegWrite is never asserted in more than one consecutive cycle.
- mem_ready outside FETCH/MEMRD/MEMWR is ignored.
- Cycle counts with mem_ready tied to 1: lw=5, sw=4, R-type=4, addi=4, beq=3, j=3.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state enumeration,
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI),
  - ALUOp, ALUSrcB and PCSource encodings.
- No sub-module: single next-state process plus a registered state, a combinational output decode, and the counter.

Test Plan:
- rst=0 held 3 cycles mid-MEMRD, then released -> state_o=0, retired=0, no RegWrite pulse.
- mem_ready=1 constant, opcode=000000 -> states 0,1,6,7,0; RegWrite=1 with RegDst=1 only in state 7; retired=1.
- lw with mem_ready low for 2 cycles in FETCH and 3 in MEMRD -> IRWrite pulses once, exactly on the ready cycle; MEMWB has RegWrite=1, MemtoReg=1; total 10 cycles.
- beq with zero=1, then zero=0 -> PCWriteCond=1, PCSource=01 in BRANCH both times; retired increments by 2.
- opcode=111111 -> DECODE to FETCH, illegal pulses one cycle, retired unchanged.
- CNT_W=4, 16 consecutive j instructions -> retired saturates at 15.
